spi_cfg_bank: RTL and testbench
===============================

# spi_cfg_bank

Parametrised SPI-slave configuration register bank, clocked by the serial clock. It supersedes the fixed 72-bit write-only programmer with the following:
- an addressed command byte;
- auto-incrementing burst writes and reads;
- SDO readback;
- a sticky status register.

It sits between the chip's SPI pads and the analog/digital trim field decode, which slices `cfg_q`.

## Interface
Parameters:
- `NUM_BYTES`, 9, number of configuration bytes, 1..126.
- `RESET_VALUE`, '0, `NUM_BYTES*8`-bit power-on value of `cfg_q`.

Ports:
- `SCLK` input 1: serial clock, the block's only clock. It runs only while `CS` is low.
- `reset` input 1: asynchronous, active-low reset of everything.
- `CS` input 1: chip select, active-low. A high level asynchronously clears frame state only (counters, state, shift register); `cfg_q` and status are untouched.
- `SDI` input 1: serial data in, MSB first.
- `SDO` output 1: serial readback data.
- `SDO_OE` output 1: pad enable; high only in `ST_READ` with `CS` low.
- `cfg_q` output `NUM_BYTES*8`: register bank; byte n is at `[8n+7:8n]`.
- `byte_wr` output `NUM_BYTES`: one-`SCLK` pulse on the edge where byte n is written.

## Operation
- Frame: the command byte, then N data bytes. Command bit 7 = 1 selects read, 0 selects write. Command bits 6:0 are the start address.
- States: `ST_CMD`, `ST_WRITE`, `ST_READ`, `ST_IGNORE`. `ST_CMD` is entered on `CS` high or `reset`.
- `ST_CMD` → `ST_WRITE` or `ST_READ` on the edge that completes the command byte.
- Write: each completed data byte is stored to `cfg_q` byte[addr] and pulses `byte_wr[addr]`; then addr increments.
- Address out of range (addr ≥ `NUM_BYTES`, other than 7'h7F): the write is dropped, `ovf_err` is set, and addr still increments.
- Address 7'h7F is the status register: `{6'b0, par_err, ovf_err}`. It is read-only; writes to it are dropped without error.
- Address counter is 7 bits and saturates at 7'h7F; there is no wrap. Once saturated, later bytes are dropped and set `ovf_err`.
- Read: bytes are shifted out MSB first from the current addr, and addr increments per byte.
  - Out-of-range addresses read 8'h00 and set `ovf_err`.
  - A completed read of 7'h7F clears both status flags after that byte.
- `CS` rising mid-byte discards the partial byte and writes nothing. Any bytes already completed remain written.
- `reset` low: `cfg_q` = `RESET_VALUE`, status = 0, `byte_wr` = 0, `SDO` = 0, `SDO_OE` = 0, state = `ST_CMD`.

## Timing
- `SDI` is sampled on `SCLK` rising edges. Rising edges are numbered from 1 per frame.
- Command decode happens at rising edge 8.
- Data byte k (k = 0..) completes at rising edge 16+8k. `cfg_q` updates and `byte_wr` asserts at that edge; `byte_wr` deasserts at the next rising edge.
- `SDO` is registered on `SCLK` falling edges.
  - The falling edge after rising edge 8+8k+j drives bit 7−j of byte k, for j = 0..7.
  - The host samples it on the next rising edge.
  - The source byte is sampled live, so a byte written earlier in the same frame reads back its new value.
- `SDO_OE` rises on the falling edge after rising edge 8 and clears asynchronously with `CS` high.
- Write latency from the last data bit is 0 cycles: it lands on the same edge.

## Configuration
- Macro: `SPI_CFG_PARITY_EN`.
- Defined:
  - every byte, command included, carries a 9th bit of odd parity, sampled after its LSB, so bytes are 9 `SCLK` periods long;
  - a data byte with bad parity is not written, no `byte_wr` pulse is issued, `par_err` is set, and addr still increments;
  - a command byte with bad parity moves the state to `ST_IGNORE` until `CS` goes high, with `SDO_OE` held at 0;
  - in read mode, `SDO` drives the odd-parity bit in the 9th slot.
- Undefined: bytes are 8 bits, no parity logic is built, and `par_err` is tied to 0.

## Structure
- Package `spi_cfg_pkg` holds:
  - `ADDR_W` = 7;
  - `STATUS_ADDR` = 7'h7F;
  - `CMD_RD_BIT` = 7;
  - the state enum `spi_cfg_state_t`;
  - `BYTE_BITS`, which is 9 or 8 depending on `SPI_CFG_PARITY_EN`.
- Sub-module `spi_cfg_rx`: bit counter, `SDI` shift register, byte-complete strobe and parity check. It is cleared by `reset` low or `CS` high.
- The top level holds the FSM, address counter, register bank, status register and falling-edge `SDO` register.

## Test plan
- After reset with `RESET_VALUE` = 72'h0: send cmd 8'h00, then 02 DE EC ED 58 A8 C8 68 6E → `cfg_q` = 72'h6E68C8A858EDECDE02, and `byte_wr[0]`..`[8]` pulse at rising edges 16..80.
- Write cmd 8'h03 with 8'h5A 8'hA5 → bytes 3 and 4 change, all other bytes are unchanged, and status is 0.
- Read cmd 8'h83 → `SDO` shifts 8'h5A then 8'hA5, `SDO_OE` is high from the falling edge after rising edge 8, and there is no change to `cfg_q`.
- Write cmd 8'h08 with 3 bytes at `NUM_BYTES` = 9 → byte 8 is written. Read cmd 8'hFF then returns 8'h01 (`ovf_err`); a second read of 8'hFF returns 8'h00.
- Write cmd 8'h00, then `CS` rises after 4 bits of data byte 1 → byte 0 is written and byte 1 is unchanged. Asserting `reset` low mid-frame → `cfg_q` = `RESET_VALUE` and `SDO` = 0 immediately.
- With `SPI_CFG_PARITY_EN`: a data byte sent with wrong parity → not written, status reads 8'h02. A command byte with wrong parity → no writes, `SDO_OE` stays 0.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants, state encoding and parity helper for the SPI configuration bank.
// SPI_CFG_PARITY_EN switches bytes to 9 bits (8 data + odd parity).
package spi_cfg_pkg;

  localparam int ADDR_W     = 7;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F;
  localparam int CMD_RD_BIT = 7;

`ifdef SPI_CFG_PARITY_EN
  localparam int BYTE_BITS = 9;
  localparam int CNT_W     = 4;
`else
  localparam int BYTE_BITS = 8;
  localparam int CNT_W     = 3;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_BITS - 1);

  typedef enum logic [1:0] {
    ST_CMD    = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_IGNORE = 2'd3
  } spi_cfg_state_t;

  // Bit that makes the 9-bit word {d, p} carry an odd number of ones.
  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/spi_cfg_bank_if.sv
// Pad-side SPI signals of the configuration bank; the host drives CS/SDI, the bank drives SDO/SDO_OE.
interface spi_cfg_bank_if;
  logic CS;
  logic SDI;
  logic SDO;
  logic SDO_OE;

  modport master (output CS, output SDI, input SDO, input SDO_OE);
  modport slave  (input CS, input SDI, output SDO, output SDO_OE);
endinterface

// File: rtl/spi_cfg_rx.sv
// Serial receive front end: bit counter, SDI shift register, byte-complete strobe and
// (with SPI_CFG_PARITY_EN) odd-parity check of the byte finishing on the current edge.
module spi_cfg_rx
  import spi_cfg_pkg::*;
(
  input  logic             sclk,
  input  logic             frame_rst_n,
  input  logic             sdi,
  output logic [CNT_W-1:0] bit_cnt_r,
  output logic             byte_done_s,
  output logic [7:0]       byte_data_s,
  output logic             par_ok_s
);

  logic [BYTE_BITS-2:0] shift_r;

  // Bit position within the byte and the serial shift register, cleared between frames.
  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else begin
      bit_cnt_r <= byte_done_s ? '0 : bit_cnt_r + CNT_W'(1);
      shift_r   <= {shift_r[BYTE_BITS-3:0], sdi};
    end
  end

  // The final bit is still on SDI, so the completed byte is assembled combinationally.
  assign byte_done_s = (bit_cnt_r == LAST_BIT);

`ifdef SPI_CFG_PARITY_EN
  assign byte_data_s = shift_r;
  assign par_ok_s    = ^{shift_r, sdi};
`else
  assign byte_data_s = {shift_r, sdi};
  assign par_ok_s    = 1'b1;
`endif

endmodule

// File: rtl/spi_cfg_bank.sv
// SPI-slave configuration register bank clocked by SCLK: addressed burst write/read, SDO readback,
// sticky status at 7'h7F. Optional SPI_CFG_PARITY_EN adds odd parity on every byte.
module spi_cfg_bank
  import spi_cfg_pkg::*;
#(
  parameter int                     NUM_BYTES   = 9,
  parameter logic [NUM_BYTES*8-1:0] RESET_VALUE = '0
) (
  input  logic                   SCLK,
  input  logic                   reset,
  spi_cfg_bank_if.slave          spi,
  output logic [NUM_BYTES*8-1:0] cfg_q,
  output logic [NUM_BYTES-1:0]   byte_wr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  logic                   frame_rst_n_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   byte_done_s;
  logic [7:0]             byte_data_s;
  logic                   par_ok_s;
  spi_cfg_state_t         state_r, state_nxt_s;
  logic [ADDR_W-1:0]      addr_r, addr_nxt_s;
  logic                   sat_r, sat_nxt_s;
  logic [NUM_BYTES*8-1:0] cfg_q_r;
  logic [NUM_BYTES-1:0]   byte_wr_r, byte_wr_nxt_s;
  logic                   ovf_r, par_r;
  logic                   wr_en_s, ovf_set_s, stat_clr_s;
  logic                   is_stat_s, oob_s;
  logic [7:0]             rd_bank_s, rd_byte_s;
  logic                   sdo_bit_s, sdo_r, sdo_oe_r;

  assign frame_rst_n_s = reset & ~spi.CS;

  spi_cfg_rx u_rx (
    .sclk        (SCLK),
    .frame_rst_n (frame_rst_n_s),
    .sdi         (spi.SDI),
    .bit_cnt_r   (bit_cnt_r),
    .byte_done_s (byte_done_s),
    .byte_data_s (byte_data_s),
    .par_ok_s    (par_ok_s)
  );

  // Once the counter has tried to step past 7'h7F, every further byte is out of range.
  assign is_stat_s = !sat_r && (addr_r == STATUS_ADDR);
  assign oob_s     = sat_r || ((addr_r != STATUS_ADDR) && (addr_r > LAST_ADDR));

  // Frame FSM, address stepping and per-byte write/status decisions.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    sat_nxt_s   = sat_r;
    wr_en_s     = 1'b0;
    ovf_set_s   = 1'b0;
    stat_clr_s  = 1'b0;
    if (byte_done_s) begin
      case (state_r)
        ST_CMD: begin
          addr_nxt_s = byte_data_s[ADDR_W-1:0];
          if (!par_ok_s) begin
            state_nxt_s = ST_IGNORE;
          end else if (byte_data_s[CMD_RD_BIT]) begin
            state_nxt_s = ST_READ;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end
        ST_WRITE, ST_READ: begin
          if (state_r == ST_WRITE) begin
            if (!par_ok_s) begin
              wr_en_s = 1'b0;
            end else if (oob_s) begin
              ovf_set_s = 1'b1;
            end else if (is_stat_s) begin
              wr_en_s = 1'b0;
            end else begin
              wr_en_s = 1'b1;
            end
          end else begin
            if (oob_s) begin
              ovf_set_s = 1'b1;
            end else if (is_stat_s) begin
              stat_clr_s = 1'b1;
            end else begin
              stat_clr_s = 1'b0;
            end
          end
          if (addr_r == STATUS_ADDR) begin
            sat_nxt_s = 1'b1;
          end else begin
            addr_nxt_s = addr_r + 7'd1;
          end
        end
        ST_IGNORE: state_nxt_s = ST_IGNORE;
        default:   state_nxt_s = ST_CMD;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // One-hot write strobe for the byte being stored on this edge.
  always_comb begin
    byte_wr_nxt_s = '0;
    for (int n = 0; n < NUM_BYTES; n++) begin
      byte_wr_nxt_s[n] = wr_en_s && (addr_r == ADDR_W'(n));
    end
  end

  // Frame-scoped state, cleared whenever CS is high.
  always_ff @(posedge SCLK or negedge frame_rst_n_s) begin
    if (!frame_rst_n_s) begin
      state_r   <= ST_CMD;
      addr_r    <= '0;
      sat_r     <= 1'b0;
      byte_wr_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      addr_r    <= addr_nxt_s;
      sat_r     <= sat_nxt_s;
      byte_wr_r <= byte_wr_nxt_s;
    end
  end

  // Register bank, persistent across frames.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      cfg_q_r <= RESET_VALUE;
    end else begin
      for (int n = 0; n < NUM_BYTES; n++) begin
        if (byte_wr_nxt_s[n]) begin
          cfg_q_r[8*n +: 8] <= byte_data_s;
        end
      end
    end
  end

  // Sticky overflow flag; a completed status read clears it.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (stat_clr_s) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end
  end

`ifdef SPI_CFG_PARITY_EN
  logic par_set_s;
  assign par_set_s = byte_done_s && (state_r == ST_WRITE) && !par_ok_s;

  // Sticky data-parity flag; a completed status read clears it.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      par_r <= 1'b0;
    end else if (stat_clr_s) begin
      par_r <= 1'b0;
    end else if (par_set_s) begin
      par_r <= 1'b1;
    end
  end
`else
  assign par_r = 1'b0;
`endif

  // Live readback mux from the bank at the current address.
  always_comb begin
    rd_bank_s = 8'h00;
    for (int n = 0; n < NUM_BYTES; n++) begin
      rd_bank_s = rd_bank_s | ({8{addr_r == ADDR_W'(n)}} & cfg_q_r[8*n +: 8]);
    end
  end

  // Source byte for SDO: zero when out of range, status at 7'h7F.
  always_comb begin
    if (oob_s) begin
      rd_byte_s = 8'h00;
    end else if (is_stat_s) begin
      rd_byte_s = {6'b000000, par_r, ovf_r};
    end else begin
      rd_byte_s = rd_bank_s;
    end
  end

`ifdef SPI_CFG_PARITY_EN
  assign sdo_bit_s = (bit_cnt_r == LAST_BIT) ? odd_par(rd_byte_s)
                                             : rd_byte_s[3'd7 - bit_cnt_r[2:0]];
`else
  assign sdo_bit_s = rd_byte_s[3'd7 - bit_cnt_r];
`endif

  // SDO and its pad enable launch on the falling edge for host capture on the next rising edge.
  always_ff @(negedge SCLK or negedge frame_rst_n_s) begin
    if (!frame_rst_n_s) begin
      sdo_r    <= 1'b0;
      sdo_oe_r <= 1'b0;
    end else begin
      sdo_oe_r <= (state_r == ST_READ);
      sdo_r    <= (state_r == ST_READ) & sdo_bit_s;
    end
  end

  assign spi.SDO    = sdo_r;
  assign spi.SDO_OE = sdo_oe_r;
  assign cfg_q      = cfg_q_r;
  assign byte_wr    = byte_wr_r;

endmodule

// File: tb/tb_spi_cfg_bank.sv
// Scoreboard bench for spi_cfg_bank: expected byte_wr pulses and SDO bytes are queued
// as frames are built and compared as the DUT produces them.
module tb_spi_cfg_bank;
  import spi_cfg_pkg::*;

  localparam int NB = 9;
  localparam int BB = BYTE_BITS;

  typedef struct {
    int            edge_n;
    logic [NB-1:0] mask;
  } wr_ev_t;

  logic            SCLK;
  logic            reset;
  logic [NB*8-1:0] cfg_q;
  logic [NB-1:0]   byte_wr;

  spi_cfg_bank_if spi ();

  spi_cfg_bank #(.NUM_BYTES(NB), .RESET_VALUE(72'h0)) dut (
    .SCLK    (SCLK),
    .reset   (reset),
    .spi     (spi),
    .cfg_q   (cfg_q),
    .byte_wr (byte_wr)
  );

  int              total;
  int              bad;
  wr_ev_t          exp_wr_q[$];
  logic [7:0]      exp_rd_q[$];
  logic [NB*8-1:0] model;

  // Expect data byte k of the next frame to land at bank address addr.
  task automatic push_wr(input int k, input int addr, input logic [7:0] d);
    wr_ev_t ev;
    ev.edge_n = BB * (k + 2);
    ev.mask   = NB'(1) << addr;
    exp_wr_q.push_back(ev);
    model[8*addr +: 8] = d;
  endtask

  // One frame of n bytes (first byte in the top of the n-byte region of b). bad_idx flips that
  // byte's parity, cut >= 0 stops after that many bits, rd expects SDO readback.
  task automatic frame(input int n, input logic [95:0] b, input int bad_idx, input int cut, input bit rd);
    int         nbits;
    int         bi;
    int         bp;
    int         pos;
    logic [7:0] cur;
    logic [7:0] rd_sh;
    logic [7:0] exp_b;
    logic [NB-1:0] exp_m;
    wr_ev_t     ev;
    nbits = (cut >= 0) ? cut : n * BB;
    rd_sh = 8'h00;
    spi.CS = 1'b0;
    #5;
    for (int e = 1; e <= nbits; e++) begin
      bi  = (e - 1) / BB;
      bp  = (e - 1) % BB;
      cur = b[8*(n-1-bi) +: 8];
      if (bp < 8) spi.SDI = cur[7-bp];
      else        spi.SDI = odd_par(cur) ^ (bi == bad_idx);
      #4 SCLK = 1'b1;
      #1;
      exp_m = '0;
      if (exp_wr_q.size() > 0 && exp_wr_q[0].edge_n == e) begin
        ev    = exp_wr_q.pop_front();
        exp_m = ev.mask;
      end
      total++;
      if (byte_wr !== exp_m) begin
        bad++;
        $display("FAIL byte_wr edge %0d: got %h want %h", e, byte_wr, exp_m);
      end
      #4 SCLK = 1'b0;
      #1;
      total++;
      if (spi.SDO_OE !== (rd && e >= BB)) begin
        bad++;
        $display("FAIL sdo_oe edge %0d: got %b want %b", e, spi.SDO_OE, (rd && e >= BB));
      end
      if (rd && e >= BB) begin
        pos = (e - BB) % BB;
        if (pos < 8) rd_sh = {rd_sh[6:0], spi.SDO};
        if (pos == 7) begin
          total++;
          if (exp_rd_q.size() == 0) begin
            bad++;
            $display("FAIL sdo_extra edge %0d: got %h want no byte", e, rd_sh);
          end else begin
            exp_b = exp_rd_q.pop_front();
            if (rd_sh !== exp_b) begin
              bad++;
              $display("FAIL sdo_byte edge %0d: got %h want %h", e, rd_sh, exp_b);
            end
          end
        end
        if (pos == 8) begin
          total++;
          if (spi.SDO !== odd_par(rd_sh)) begin
            bad++;
            $display("FAIL sdo_par edge %0d: got %b want %b", e, spi.SDO, odd_par(rd_sh));
          end
        end
      end
      #4;
    end
    spi.CS  = 1'b1;
    spi.SDI = 1'b0;
    #10;
    total++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got wr=%0d rd=%0d pending want 0", exp_wr_q.size(), exp_rd_q.size());
    end
    exp_wr_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic clk_bit(input logic v);
    spi.SDI = v;
    #4 SCLK = 1'b1;
    #5 SCLK = 1'b0;
    #5;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #10;
    total++;
    if (cfg_q !== 72'h0) begin bad++; $display("FAIL reset_cfg: got %h want 0", cfg_q); end
    total++;
    if (byte_wr !== 9'h0) begin bad++; $display("FAIL reset_wr: got %h want 0", byte_wr); end
    total++;
    if (spi.SDO !== 1'b0 || spi.SDO_OE !== 1'b0) begin
      bad++; $display("FAIL reset_sdo: got %b/%b want 0/0", spi.SDO, spi.SDO_OE);
    end
    reset = 1'b1;
    #10;
    exp_rd_q.push_back(8'h00);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
  endtask

  task automatic test_burst_write();
    logic [7:0] d [9];
    d = '{8'h02, 8'hDE, 8'hEC, 8'hED, 8'h58, 8'hA8, 8'hC8, 8'h68, 8'h6E};
    for (int k = 0; k < 9; k++) push_wr(k, k, d[k]);
    frame(10, {8'h00, 8'h02, 8'hDE, 8'hEC, 8'hED, 8'h58, 8'hA8, 8'hC8, 8'h68, 8'h6E}, -1, -1, 1'b0);
    total++;
    if (cfg_q !== 72'h6E68C8A858EDECDE02) begin
      bad++; $display("FAIL burst_cfg: got %h want 6e68c8a858edecde02", cfg_q);
    end
  endtask

  task automatic test_write_mid();
    push_wr(0, 3, 8'h5A);
    push_wr(1, 4, 8'hA5);
    frame(3, {8'h03, 8'h5A, 8'hA5}, -1, -1, 1'b0);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL mid_cfg: got %h want %h", cfg_q, model); end
    exp_rd_q.push_back(8'h00);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
  endtask

  task automatic test_read();
    exp_rd_q.push_back(8'h5A);
    exp_rd_q.push_back(8'hA5);
    frame(3, {8'h83, 8'h00, 8'h00}, -1, -1, 1'b1);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL read_cfg: got %h want %h", cfg_q, model); end
  endtask

  task automatic test_overflow();
    push_wr(0, 8, 8'h11);
    frame(4, {8'h08, 8'h11, 8'h22, 8'h33}, -1, -1, 1'b0);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL ovf_cfg: got %h want %h", cfg_q, model); end
    exp_rd_q.push_back(8'h01);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
    exp_rd_q.push_back(8'h00);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
    // Burst read running off the end of the bank.
    exp_rd_q.push_back(8'h68);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h00);
    frame(4, {8'h87, 24'h0}, -1, -1, 1'b1);
    exp_rd_q.push_back(8'h01);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
  endtask

  task automatic test_saturate();
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h01);
    exp_rd_q.push_back(8'h00);
    frame(4, {8'hFE, 24'h0}, -1, -1, 1'b1);
    exp_rd_q.push_back(8'h01);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
    frame(2, {8'h7F, 8'h99}, -1, -1, 1'b0);
    exp_rd_q.push_back(8'h00);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL sat_cfg: got %h want %h", cfg_q, model); end
  endtask

  task automatic test_abort();
    push_wr(0, 0, 8'hAA);
    frame(3, {8'h00, 8'hAA, 8'h55}, -1, 2*BB + 4, 1'b0);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL abort_cfg: got %h want %h", cfg_q, model); end
    total++;
    if (cfg_q[15:8] !== 8'hDE) begin bad++; $display("FAIL abort_b1: got %h want de", cfg_q[15:8]); end
  endtask

`ifdef SPI_CFG_PARITY_EN
  task automatic test_parity();
    push_wr(0, 0, 8'h11);
    frame(3, {8'h00, 8'h11, 8'h22}, 2, -1, 1'b0);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL par_data_cfg: got %h want %h", cfg_q, model); end
    exp_rd_q.push_back(8'h02);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
    frame(2, {8'h00, 8'h77}, 0, -1, 1'b0);
    total++;
    if (cfg_q !== model) begin bad++; $display("FAIL par_cmd_cfg: got %h want %h", cfg_q, model); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] cmd;
    frame(2, {8'h0A, 8'h33}, -1, -1, 1'b0);
    cmd = 8'h84;
    spi.CS = 1'b0;
    #5;
    for (int i = 0; i < BB; i++) clk_bit((i < 8) ? cmd[7-i] : odd_par(cmd));
    total++;
    if (spi.SDO !== 1'b1 || spi.SDO_OE !== 1'b1) begin
      bad++; $display("FAIL pre_reset_sdo: got %b/%b want 1/1", spi.SDO, spi.SDO_OE);
    end
    reset = 1'b0;
    #1;
    total++;
    if (cfg_q !== 72'h0) begin bad++; $display("FAIL midrst_cfg: got %h want 0", cfg_q); end
    total++;
    if (spi.SDO !== 1'b0 || spi.SDO_OE !== 1'b0) begin
      bad++; $display("FAIL midrst_sdo: got %b/%b want 0/0", spi.SDO, spi.SDO_OE);
    end
    #5;
    spi.CS = 1'b1;
    #5;
    reset = 1'b1;
    #10;
    model = '0;
    exp_rd_q.push_back(8'h00);
    frame(2, {8'hFF, 8'h00}, -1, -1, 1'b1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    SCLK    = 1'b0;
    reset   = 1'b0;
    spi.CS  = 1'b1;
    spi.SDI = 1'b0;
    model   = '0;
    test_reset();
    test_burst_write();
    test_write_mid();
    test_read();
    test_overflow();
    test_saturate();
    test_abort();
`ifdef SPI_CFG_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
